// File: rtl/green_led_pwm_driver_pkg.sv
// -----------------------------------------------------------------------------
// green_led_pwm_driver_pkg
// Shared definitions for the green-LED PWM driver: the register address map,
// the bit positions inside CTRL and the reset values of the writable registers.
// No ports; imported by green_led_pwm_driver.
// -----------------------------------------------------------------------------
package green_led_pwm_driver_pkg;

    // Avalon-MM word addresses of the configuration registers
    typedef enum logic [1:0] {
        ADDR_CTRL   = 2'd0,
        ADDR_DUTY   = 2'd1,
        ADDR_BLINK  = 2'd2,
        ADDR_STATUS = 2'd3
    } reg_addr_e;

    // CTRL bit indices
    localparam int CTRL_EN    = 0;
    localparam int CTRL_BLINK = 1;
    localparam int CTRL_INV   = 2;

    // Reset values
    localparam logic [2:0] CTRL_RST  = 3'b001;
    localparam logic [7:0] DUTY_RST  = 8'hFF;
    localparam int         BLINK_RST = 250;

endpackage

// File: rtl/led_pwm_timebase.sv
// -----------------------------------------------------------------------------
// led_pwm_timebase
// Prescaler plus 8-bit PWM counter for the green-LED driver. The prescaler
// divides clk by PRESCALE; each prescaler tick advances the PWM counter, and the
// tick on which the PWM counter rolls 255->0 is flagged as a wrap.
//
// Ports
//   clk        in   system clock
//   reset_n    in   synchronous active-low reset
//   i_enable   in   0 clears and holds both counters at zero
//   o_pwm_cnt  out  current PWM counter value
//   o_wrap     out  1 in the cycle that ends a 256-tick PWM period
// -----------------------------------------------------------------------------
module led_pwm_timebase #(
    parameter int PRESCALE = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_enable,
    output logic [7:0] o_pwm_cnt,
    output logic       o_wrap
);

    localparam int               PRE_W   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] r_pre_cnt;
    logic [7:0]       r_pwm_cnt;
    logic             w_tick;

    // Gated by enable so that the first disabled cycle (counters not yet
    // cleared) cannot produce a stray tick or wrap.
    assign w_tick = i_enable & (r_pre_cnt == PRE_MAX);

    always_ff @(posedge clk) begin
        if (!reset_n || !i_enable) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else begin
            if (w_tick) begin
                r_pre_cnt <= '0;
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end else begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
            end
        end
    end

    assign o_pwm_cnt = r_pwm_cnt;
    assign o_wrap    = w_tick & (r_pwm_cnt == 8'hFF);

endmodule

// File: rtl/green_led_pwm_driver.sv
// -----------------------------------------------------------------------------
// green_led_pwm_driver
// Takes the 9-bit pattern from the green-LED PIO, applies global PWM dimming
// and optional blinking, and drives the LEDG pins through a register. Has a
// small Avalon-MM slave for configuration (CTRL, DUTY, BLINK_PERIOD, STATUS).
//
// Ports
//   clk          in   system clock
//   reset_n      in   synchronous active-low reset
//   address      in   Avalon-MM word address
//   chipselect   in   Avalon-MM select
//   write_n      in   Avalon-MM write strobe, active-low
//   writedata    in   Avalon-MM write data
//   readdata     out  Avalon-MM read data, combinational (zero wait)
//   led_pattern  in   pattern from the PIO out_port
//   led_out      out  registered drive to the LEDG pins
// -----------------------------------------------------------------------------
module green_led_pwm_driver
    import green_led_pwm_driver_pkg::*;
#(
    parameter int LED_WIDTH = 9,
    parameter int PRESCALE  = 50,
    parameter int BLINK_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic [LED_WIDTH-1:0] led_pattern,
    output logic [LED_WIDTH-1:0] led_out
);

    logic [2:0]           r_ctrl;
    logic [7:0]           r_duty;
    logic [BLINK_W-1:0]   r_blink_per;
    logic [7:0]           r_duty_sh;
    logic [BLINK_W-1:0]   r_blink_cnt;
    logic                 r_blink_phase;
    logic [LED_WIDTH-1:0] r_led_out;

    logic                 w_wr;
    logic                 w_blink_wr;
    logic                 w_en;
    logic [7:0]           w_pwm_cnt;
    logic                 w_wrap;
    logic                 w_pwm_on;
    logic                 w_blink_last;
    logic                 w_gate;
    logic [LED_WIDTH-1:0] w_v;
    logic                 w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_blink_wr     = w_wr & (reg_addr_e'(address) == ADDR_BLINK);
    assign w_en           = r_ctrl[CTRL_EN];
    assign w_unused_wdata = ^writedata;

    led_pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_enable  (w_en),
        .o_pwm_cnt (w_pwm_cnt),
        .o_wrap    (w_wrap)
    );

    // Register file; STATUS is read-only so its writes fall through.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ctrl      <= CTRL_RST;
            r_duty      <= DUTY_RST;
            r_blink_per <= BLINK_W'(BLINK_RST);
        end else if (w_wr) begin
            case (reg_addr_e'(address))
                ADDR_CTRL:  r_ctrl      <= writedata[2:0];
                ADDR_DUTY:  r_duty      <= writedata[7:0];
                ADDR_BLINK: r_blink_per <= writedata[BLINK_W-1:0];
                default:    ;
            endcase
        end
    end

    // Duty shadow: only changes at a period boundary so a DUTY write never
    // produces a partial period. r_duty is the pre-write value here, so a
    // write landing in the wrap cycle waits for the following wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_duty_sh <= DUTY_RST;
        end else if (!w_en || w_wrap) begin
            r_duty_sh <= r_duty;
        end
    end

    // 8'hFF is special-cased so that full duty is on for all 256 counts.
    assign w_pwm_on = (r_duty_sh == 8'hFF) | (w_pwm_cnt < r_duty_sh);

    assign w_blink_last = (r_blink_cnt == (r_blink_per - 1'b1));

    // Blink counter counts PWM periods; a BLINK_PERIOD write restarts the
    // sequence in the visible phase and beats a coincident wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (!w_en || !r_ctrl[CTRL_BLINK] || w_blink_wr) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_wrap && (r_blink_per != '0)) begin
            if (w_blink_last) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_gate = w_pwm_on & r_blink_phase;
    assign w_v    = w_en ? (led_pattern & {LED_WIDTH{w_gate}}) : '0;

    // Output register; inversion is applied after the enable masking so a
    // disabled, inverted driver lights every LED.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_led_out <= '0;
        end else begin
            r_led_out <= r_ctrl[CTRL_INV] ? ~w_v : w_v;
        end
    end

    assign led_out = r_led_out;

    always_comb begin
        readdata = '0;
        case (reg_addr_e'(address))
            ADDR_CTRL:   readdata[2:0]         = r_ctrl;
            ADDR_DUTY:   readdata[7:0]         = r_duty;
            ADDR_BLINK:  readdata[BLINK_W-1:0] = r_blink_per;
            ADDR_STATUS: begin
                readdata[0]    = r_blink_phase;
                readdata[1]    = w_pwm_on;
                readdata[15:8] = w_pwm_cnt;
            end
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_green_led_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_green_led_pwm_driver
// Directed bench for green_led_pwm_driver with PRESCALE=2 (512-cycle PWM
// period). The stimulus process pushes the expected led_out / readdata value
// for the current cycle into a queue; the monitor pops and compares on the
// falling edge. All expected values are hand-derived from the timeline below,
// where R is the cycle of the last reset edge before release:
//   wrap edges at R+512*m; duty_sh reloads there.
// -----------------------------------------------------------------------------
module tb_green_led_pwm_driver;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [8:0]  led_pattern;
    logic [8:0]  led_out;

    green_led_pwm_driver #(
        .LED_WIDTH (9),
        .PRESCALE  (2),
        .BLINK_W   (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .led_pattern (led_pattern),
        .led_out     (led_out)
    );

    typedef struct {
        int          cyc;
        bit          sel;   // 0: led_out, 1: readdata
        logic [31:0] exp;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc;
    int    n_cmp;
    int    n_bad;
    int    R;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: compares everything scheduled for the current cycle.
    always @(negedge clk) begin
        exp_t        e;
        string       nm;
        logic [31:0] act;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = e.sel ? readdata : {23'b0, led_out};
            n_cmp = n_cmp + 1;
            if (e.cyc != cyc || act !== e.exp) begin
                n_bad = n_bad + 1;
                $display("FAIL %s at cyc %0d (rel %0d): got %h, expected %h",
                         nm, cyc, cyc - R, act, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_led(input string nm, input logic [8:0] v);
        exp_t e;
        e.cyc = cyc;
        e.sel = 1'b0;
        e.exp = {23'b0, v};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic expect_rd(input string nm, input logic [1:0] a, input logic [31:0] v);
        exp_t e;
        address = a;
        e.cyc = cyc;
        e.sel = 1'b1;
        e.exp = v;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        R           = 0;
        reset_n     = 1'b0;
        address     = 2'd0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        writedata   = 32'd0;
        led_pattern = 9'h1AB;

        // ---- reset state ----
        step(); expect_led("rst_led", 9'h000); expect_rd("rst_ctrl", 2'd0, 32'h1);
        step(); expect_rd("rst_duty", 2'd1, 32'hFF);
        step(); expect_rd("rst_blink", 2'd2, 32'd250);
        step(); expect_rd("rst_status", 2'd3, 32'h0003);
        step(); expect_led("rst_led2", 9'h000);
        reset_n = 1'b1;
        R = cyc;
        step(); expect_led("post_rst_1", 9'h1AB);
        step(); expect_led("post_rst_2", 9'h1AB); expect_rd("post_rst_duty", 2'd1, 32'hFF);

        // ---- duty 64: on 128 cycles, off 384 ----
        led_pattern = 9'h1FF;
        bus_write(2'd1, 32'd64);
        expect_rd("duty64_rd", 2'd1, 32'h40);
        while (cyc < R + 513) step();
        while (cyc <= R + 1024) begin
            expect_led("duty64_led", (cyc <= R + 640) ? 9'h1FF : 9'h000);
            if (cyc == R + 600) expect_rd("status_on", 2'd3, 32'h2C03);
            if (cyc == R + 700) expect_rd("status_off", 2'd3, 32'h5E01);
            step();
        end
        expect_led("duty64_next", 9'h1FF);

        // ---- DUTY write in the wrap cycle ----
        while (cyc < R + 1030) step();
        bus_write(2'd1, 32'd128);
        while (cyc < R + 1537) step();
        while (cyc <= R + 3072) begin
            if (cyc <= R + 1792)      expect_led("duty128_a", 9'h1FF);
            else if (cyc <= R + 2048) expect_led("duty128_a", 9'h000);
            else if (cyc <= R + 2304) expect_led("duty128_b", 9'h1FF);
            else                      expect_led("duty0", 9'h000);
            if (cyc == R + 2047) bus_write(2'd1, 32'd0);
            else step();
        end

        // ---- blink, period 2 ----
        bus_write(2'd1, 32'd255);
        bus_write(2'd2, 32'd2);
        bus_write(2'd0, 32'h3);
        expect_rd("blink_per_rd", 2'd2, 32'd2);
        while (cyc < R + 3585) step();
        while (cyc <= R + 7300) begin
            if ((cyc <= R + 4096) ||
                (cyc >= R + 5121 && cyc <= R + 6144) ||
                (cyc >= R + 6402 && cyc <= R + 7168))
                expect_led("blink_led", 9'h1FF);
            else
                expect_led("blink_led", 9'h000);
            if (cyc == R + 4095) expect_rd("blink_st_a", 2'd3, 32'hFF03);
            if (cyc == R + 4096) expect_rd("blink_st_b", 2'd3, 32'h0002);
            if (cyc == R + 5121) expect_rd("blink_st_c", 2'd3, 32'h0003);
            if (cyc == R + 6401) expect_rd("blink_restart", 2'd3, 32'h8003);
            if (cyc == R + 6400) bus_write(2'd2, 32'd2);
            else step();
        end

        // ---- reset mid blink-off with a simultaneous write ----
        reset_n = 1'b0;
        bus_write(2'd0, 32'h4);
        reset_n = 1'b1;
        expect_led("rst2_led", 9'h000); expect_rd("rst2_ctrl", 2'd0, 32'h1);
        step(); expect_led("rst2_led_on", 9'h1FF); expect_rd("rst2_status", 2'd3, 32'h0003);
        step(); expect_rd("rst2_duty", 2'd1, 32'hFF);
        step(); expect_rd("rst2_blink", 2'd2, 32'd250);

        // ---- disabled + invert, then enabled + invert ----
        step();
        bus_write(2'd0, 32'h4);
        step(); expect_led("dis_inv", 9'h1FF);
        led_pattern = 9'h00F;
        bus_write(2'd0, 32'h5);
        expect_led("dis_inv_hold", 9'h1FF); expect_rd("en_status", 2'd3, 32'h0003);
        step(); expect_led("en_inv", 9'h1F0);

        step();
        step();
        if (exp_q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL %0d expectations never compared", exp_q.size());
        end
        if (n_cmp < 12) begin
            n_bad = n_bad + 1;
            $display("FAIL only %0d comparisons performed", n_cmp);
        end
        if (n_bad == 0)
            $display("PASS all %0d comparisons matched", n_cmp);
        else
            $display("FAIL %0d mismatches", n_bad);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
